// File: rtl/message_tx_serializer.sv
`default_nettype none
// ============================================================================
// message_tx_serializer : MSB-first serializer, each bit held BIT_CYCLES clocks.
// Optional even-parity trailer bit when MSG_TX_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
module message_tx_serializer #(
    parameter int MSG_WIDTH  = 120,
    parameter int BIT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSG_WIDTH-1:0] message_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 data_o,
    output logic                 bit_strobe_o,
    output logic [6:0]           bit_index_o,
    output logic                 frame_done_o
);

    localparam int               CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CYC_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [6:0]       C_BIT_FIRST = 7'(MSG_WIDTH - 1);
    localparam logic [1:0]       C_ST_IDLE   = 2'd0;
    localparam logic [1:0]       C_ST_SEND   = 2'd1;
`ifdef MSG_TX_PARITY_EN
    localparam logic [1:0]       C_ST_PARITY = 2'd2;
    localparam logic [6:0]       C_PAR_INDEX = 7'd127;
`endif

    logic [1:0]           state_q, state_d;
    logic [MSG_WIDTH-1:0] shift_q, shift_d;
    logic [6:0]           bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
`ifdef MSG_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 w_frame_end;

    logic                 busy_q, busy_d;
    logic                 data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic [6:0]           index_q, index_d;
    logic                 done_q, done_d;

    // State register (outputs are registered copies of the next-state view)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
`ifdef MSG_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            busy_q    <= 1'b0;
            data_q    <= 1'b0;
            strobe_q  <= 1'b0;
            index_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_q     <= cyc_d;
`ifdef MSG_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            busy_q    <= busy_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            index_q   <= index_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cyc_d       = cyc_q;
        w_frame_end = 1'b0;
`ifdef MSG_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            C_ST_IDLE: begin
                if (start_i) begin
                    state_d   = C_ST_SEND;
                    shift_d   = message_i;
                    bit_cnt_d = C_BIT_FIRST;
                    cyc_d     = '0;
`ifdef MSG_TX_PARITY_EN
                    parity_d  = ^message_i;
`endif
                end
            end
            C_ST_SEND: begin
                if (cyc_q == C_CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_cnt_q == 7'd0) begin
`ifdef MSG_TX_PARITY_EN
                        state_d     = C_ST_PARITY;
`else
                        state_d     = C_ST_IDLE;
                        w_frame_end = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q - 7'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef MSG_TX_PARITY_EN
            C_ST_PARITY: begin
                if (cyc_q == C_CYC_LAST) begin
                    cyc_d       = '0;
                    state_d     = C_ST_IDLE;
                    w_frame_end = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            default: state_d = C_ST_IDLE;
        endcase
    end

    // Output logic: computed from the next state so every output is registered
    always_comb begin
        busy_d   = (state_d != C_ST_IDLE);
        strobe_d = busy_d && (cyc_d == '0);
        data_d   = 1'b0;
        index_d  = 7'd0;
        done_d   = w_frame_end;
        if (state_d == C_ST_SEND) begin
            data_d  = shift_d[MSG_WIDTH-1];
            index_d = bit_cnt_d;
        end
`ifdef MSG_TX_PARITY_EN
        else if (state_d == C_ST_PARITY) begin
            data_d  = parity_d;
            index_d = C_PAR_INDEX;
        end
`endif
    end

    assign busy_o       = busy_q;
    assign data_o       = data_q;
    assign bit_strobe_o = strobe_q;
    assign bit_index_o  = index_q;
    assign frame_done_o = done_q;

endmodule
`default_nettype wire

// File: doc/message_tx_serializer.md
# message_tx_serializer

Downstream stage of the 120-bit transmit message builder: captures the assembled message word on a start request and shifts it out MSB-first as a serial bitstream, each bit held for a programmable number of clock cycles. Provides busy, per-bit strobe and frame-done indications to the transmit sequencer, which in turn drives the modulator.

## Interface
- `MSG_WIDTH`, 120, message length in bits (frame payload).
- `BIT_CYCLES`, 1000, clock cycles each bit is held on `data_o`; legal range ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `message_i`  in  MSG_WIDTH  message word from the concat stage; sampled only on an accepted start.
- `start_i`  in  1  frame request; accepted only when `busy_o`=0.
- `busy_o`  out  1  high while a frame is being shifted out.
- `data_o`  out  1  serial bit; 0 when idle.
- `bit_strobe_o`  out  1  one-cycle pulse on the first cycle of every transmitted bit.
- `bit_index_o`  out  7  index of the bit currently on `data_o` (MSG_WIDTH-1 down to 0; parity bit reported as 127 when enabled); 0 when idle.
- `frame_done_o`  out  1  one-cycle pulse after the last bit period ends.

## Operation
- FSM states: IDLE, SEND, PARITY (only with macro).
- IDLE: on `start_i`=1, load `message_i` into shift register, load bit counter to MSG_WIDTH-1, clear cycle counter, go SEND.
- SEND: `data_o` = shift register MSB; cycle counter counts 0..BIT_CYCLES-1; at BIT_CYCLES-1 shift left by one, decrement bit counter, reset cycle counter. After bit 0's period: go PARITY (macro) or IDLE with `frame_done_o`=1.
- PARITY: hold parity bit for BIT_CYCLES cycles, then IDLE with `frame_done_o`=1.
- `start_i` while busy: ignored, no queuing.
- `message_i` changes during a frame: no effect on the frame in flight.
- Cycle counter width: $clog2(BIT_CYCLES), minimum 1 bit; BIT_CYCLES=1 yields a new bit and strobe every cycle.
- Reset values: `busy_o`=0, `data_o`=0, `bit_strobe_o`=0, `bit_index_o`=0, `frame_done_o`=0, state IDLE, shift register 0.

## Timing
- All outputs registered.
- Start accepted at edge T → at T+1: `busy_o`=1, `data_o`=message bit MSG_WIDTH-1, `bit_strobe_o`=1, `bit_index_o`=MSG_WIDTH-1.
- Bit k occupies cycles T+1+(MSG_WIDTH-1-k)·BIT_CYCLES for BIT_CYCLES cycles.
- Frame end (no parity): at T+1+MSG_WIDTH·BIT_CYCLES `frame_done_o`=1, `busy_o`=0, `data_o`=0, `bit_strobe_o`=0.
- `start_i`=1 in the `frame_done_o` cycle is accepted (FSM already IDLE); next frame's first bit appears one cycle later — minimum inter-frame gap is one idle cycle.
- `rst` mid-frame: next edge forces reset values; frame aborted, no `frame_done_o`.
- `rst` and `start_i` together: reset wins.

## Configuration
- `MSG_TX_PARITY_EN` defined: one even-parity bit (XOR of all MSG_WIDTH captured bits) appended after bit 0, held BIT_CYCLES cycles with its own `bit_strobe_o`; frame is MSG_WIDTH+1 bits; `frame_done_o` at T+1+(MSG_WIDTH+1)·BIT_CYCLES.
- Not defined: PARITY state and parity logic absent; frame is exactly MSG_WIDTH bits.

## Test plan
- BIT_CYCLES=4, `message_i`={103'h5a5a5a5a_5a5a5a5a, 5'd12, 6'd34, 6'd56}, start pulse at T → 120 bits MSB-first, first 39 bits 0, last 17 bits 01100_100010_111000; 120 strobes spaced 4 cycles; `frame_done_o` at T+481.
- Same stimulus with `MSG_TX_PARITY_EN` → 121st bit = 1 (39 ones, odd), `bit_index_o`=127 during it; `frame_done_o` at T+485.
- `start_i` held high continuously, BIT_CYCLES=1 → frames back-to-back with exactly one idle cycle (`busy_o`=0, `data_o`=0) between them.
- `start_i` pulses and `message_i` changed to all-ones mid-frame → transmitted bits unchanged, single `frame_done_o`.
- `rst` asserted at cycle 200 of a frame → next cycle all outputs 0, no `frame_done_o`; new start after release transmits full frame.
- `rst` and `start_i` high in same cycle → stays IDLE, `busy_o`=0.
